// File: rtl/servo_pkg.sv
// Shared definitions for the servo move sequencer.
// Contents: direction encodings, default PWM period, move-record layout
// ({dir[1:0], periods[COUNT_W-1:0]}, direction in the MSBs), FSM state type.
package servo_pkg;

    localparam int unsigned DIR_W              = 2;
    localparam int unsigned DEFAULT_PWM_PERIOD = 2000000;

    localparam logic [DIR_W-1:0] DIR_NEUTRAL = 2'b00;
    localparam logic [DIR_W-1:0] DIR_FWD     = 2'b01;
    localparam logic [DIR_W-1:0] DIR_REV     = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // The unused code 11 behaves as neutral.
    function automatic logic [DIR_W-1:0] norm_dir(input logic [DIR_W-1:0] dir);
        return (dir == 2'b11) ? DIR_NEUTRAL : dir;
    endfunction

endpackage

// File: rtl/servo_move_fifo.sv
// Synchronous move queue with push, pop, flush and occupancy status.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   push, din    - enqueue din; accepted when not full, or when popping at the same time
//   pop          - dequeue the head entry (ignored when empty)
//   flush        - drop every queued entry
//   head         - current head entry (valid while not empty)
//   level        - number of queued entries
//   full, empty  - occupancy status
module servo_move_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/servo_move_sequencer.sv
// Queues timed servo moves and replays them as one-cycle command strobes
// to a tracking-servo channel, with limit-switch kill handling.
// Ports:
//   PCLK, PRESET              - clock, synchronous active-high reset
//   push, push_dir, push_periods - enqueue a move (direction, duration in PWM periods)
//   abort                     - flush queue and go neutral
//   clear_flags               - clear overflow / limit_hit
//   stop_y                    - async active-low limits: [1] blocks reverse, [0] blocks forward
//   cmd_neutral/forward/reverse - one-cycle command strobes
//   busy                      - a move is running
//   fifo_level/full/empty     - queue status
//   remaining                 - periods left in the current move
//   overflow, limit_hit       - sticky flags
module servo_move_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned PWM_PERIOD = DEFAULT_PWM_PERIOD,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        push,
    input  logic [1:0]                  push_dir,
    input  logic [COUNT_W-1:0]          push_periods,
    input  logic                        abort,
    input  logic                        clear_flags,
    input  logic [1:0]                  stop_y,
    output logic                        cmd_neutral,
    output logic                        cmd_forward,
    output logic                        cmd_reverse,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [COUNT_W-1:0]          remaining,
    output logic                        overflow,
    output logic                        limit_hit
);

    localparam int unsigned TIMER_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int unsigned MOVE_W  = DIR_W + COUNT_W;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PWM_PERIOD - 1);

    logic [TIMER_W-1:0] timer;
    logic [1:0]         sync_a;
    logic [1:0]         sync_b;
    state_e             state;
    logic [DIR_W-1:0]   cur_dir;

    logic [MOVE_W-1:0]  push_move;
    logic [MOVE_W-1:0]  head_move;
    logic [DIR_W-1:0]   head_dir;
    logic [COUNT_W-1:0] head_periods;

    logic tick;
    logic trip;
    logic flush;
    logic pop;
    logic start;
    logic fifo_push;
    logic overflow_set;

    assign push_move    = {push_dir, push_periods};
    assign head_dir     = norm_dir(head_move[MOVE_W-1 -: DIR_W]);
    assign head_periods = head_move[COUNT_W-1:0];

    assign tick  = (timer == TIMER_LAST);
    // Only the limit on the side the current move is heading towards matters.
    assign trip  = (state == ST_RUN) &&
                   (((cur_dir == DIR_FWD) && !sync_b[0]) ||
                    ((cur_dir == DIR_REV) && !sync_b[1]));
    assign flush = abort || trip;

    // Head is consumed at a tick when idle or when the current move is on its last period.
    assign pop   = tick && !flush && !fifo_empty &&
                   ((state == ST_IDLE) || (remaining == COUNT_W'(1)));
    // Zero-period moves are consumed without starting anything.
    assign start = pop && (head_periods != '0);

    assign fifo_push    = push && !flush;
    assign overflow_set = fifo_push && fifo_full && !pop;

    assign busy = (state == ST_RUN);

    servo_move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MOVE_W)
    ) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (fifo_push),
        .pop   (pop),
        .flush (flush),
        .din   (push_move),
        .head  (head_move),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Period timer, limit synchroniser, move FSM, strobes and sticky flags.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            timer       <= '0;
            sync_a      <= 2'b11;
            sync_b      <= 2'b11;
            state       <= ST_IDLE;
            cur_dir     <= DIR_NEUTRAL;
            remaining   <= '0;
            cmd_neutral <= 1'b0;
            cmd_forward <= 1'b0;
            cmd_reverse <= 1'b0;
            overflow    <= 1'b0;
            limit_hit   <= 1'b0;
        end else begin
            timer  <= tick ? '0 : timer + TIMER_W'(1);
            sync_a <= stop_y;
            sync_b <= sync_a;

            cmd_neutral <= 1'b0;
            cmd_forward <= 1'b0;
            cmd_reverse <= 1'b0;

            if (flush) begin
                cmd_neutral <= 1'b1;
                remaining   <= '0;
                state       <= ST_IDLE;
                cur_dir     <= DIR_NEUTRAL;
            end else if (start) begin
                // New move, possibly back-to-back with the previous one.
                remaining <= head_periods;
                cur_dir   <= head_dir;
                state     <= ST_RUN;
                case (head_dir)
                    DIR_FWD: cmd_forward <= 1'b1;
                    DIR_REV: cmd_reverse <= 1'b1;
                    default: cmd_neutral <= 1'b1;
                endcase
            end else if (tick && (state == ST_RUN)) begin
                if (remaining > COUNT_W'(1)) begin
                    remaining <= remaining - COUNT_W'(1);
                end else begin
                    cmd_neutral <= 1'b1;
                    remaining   <= '0;
                    state       <= ST_IDLE;
                    cur_dir     <= DIR_NEUTRAL;
                end
            end

            // Set wins over clear.
            if (overflow_set)      overflow <= 1'b1;
            else if (clear_flags)  overflow <= 1'b0;

            if (trip && !abort)    limit_hit <= 1'b1;
            else if (clear_flags)  limit_hit <= 1'b0;
        end
    end

endmodule
